// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy bits for in-order issue/write-back tracking.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      we,
  input  logic [$clog2(NREGS)-1:0]  wsel,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0]  asel,
  input  logic [$clog2(NREGS)-1:0]  bsel,
  output logic [DATA_W-1:0]         aout,
  output logic [DATA_W-1:0]         bout,
  output logic                      a_busy,
  output logic                      b_busy,
  input  logic                      iss_valid,
  input  logic [$clog2(NREGS)-1:0]  iss_dsel,
  output logic                      iss_ready,
  output logic [$clog2(NREGS):0]    busy_cnt
);

  localparam int AW = $clog2(NREGS);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  logic wsel_zero, asel_zero, bsel_zero, dsel_zero;
  logic wr_eff, accept, iss_eff;
  logic a_hit, b_hit;
  logic cnt_inc, cnt_dec;

  always_comb begin
    wsel_zero = (ZERO_REG != 0) && (wsel == '0);
    asel_zero = (ZERO_REG != 0) && (asel == '0);
    bsel_zero = (ZERO_REG != 0) && (bsel == '0);
    dsel_zero = (ZERO_REG != 0) && (iss_dsel == '0);
  end

  // Issue handshake: iss_ready is a function of scoreboard state and the
  // write-back port only, never of iss_valid; an issue is accepted on a
  // rising edge where iss_valid && iss_ready. A write-back to the same
  // register in that cycle frees it in time for the new reservation.
  assign iss_ready = dsel_zero || !busy[iss_dsel] || (we && (wsel == iss_dsel));
  assign accept    = iss_valid && iss_ready;
  assign wr_eff    = we && !wsel_zero;
  assign iss_eff   = accept && !dsel_zero;

  // Counter tracks transitions of the busy vector: a write that is
  // immediately re-reserved leaves the bit set, so it is not a decrement.
  assign cnt_inc = iss_eff && !busy[iss_dsel];
  assign cnt_dec = wr_eff && busy[wsel] && !(iss_eff && (iss_dsel == wsel));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[wsel] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (iss_eff && (iss_dsel == AW'(i)))
          busy[i] <= 1'b1;
        else if (wr_eff && (wsel == AW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      busy_cnt <= '0;
    else if (cnt_inc && !cnt_dec)
      busy_cnt <= busy_cnt + 1'b1;
    else if (cnt_dec && !cnt_inc)
      busy_cnt <= busy_cnt - 1'b1;
  end

  assign a_hit = BYPASS && wr_eff && (wsel == asel);
  assign b_hit = BYPASS && wr_eff && (wsel == bsel);

  always_comb begin
    aout   = regs[asel];
    a_busy = busy[asel];
    if (asel_zero) begin
      aout   = '0;
      a_busy = 1'b0;
    end else if (a_hit) begin
      aout   = wdata;
      a_busy = 1'b0;
    end
  end

  always_comb begin
    bout   = regs[bsel];
    b_busy = busy[bsel];
    if (bsel_zero) begin
      bout   = '0;
      b_busy = 1'b0;
    end else if (b_hit) begin
      bout   = wdata;
      b_busy = 1'b0;
    end
  end

endmodule
